// File: rtl/track_cache_if.sv
// track_cache_if: MiSTer sd_* block-device port between a track buffer and the SD sector engine.
interface track_cache_if;
    logic [31:0] lba_fdd;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_dout;
    logic [7:0]  sd_buff_din;
    modport master (
        output lba_fdd, sd_rd, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_addr, sd_buff_wr, sd_buff_dout
    );
    modport slave (
        input  lba_fdd, sd_rd, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_addr, sd_buff_wr, sd_buff_dout
    );
endinterface

// File: rtl/track_cache.sv
// track_cache: write-back floppy track buffer with per-sector dirty tracking and idle-timeout flush.
module track_cache #(
    parameter int DRIVE_NUM  = 0,
    parameter int SECTORS    = 13,
    parameter int TRACK_W    = 6,
    parameter int IDLE_FLUSH = 2000000,
    localparam int SEC_W     = (SECTORS > 1) ? $clog2(SECTORS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               active,
    input  logic [TRACK_W-1:0] track,
    input  logic               img_mounted,
    input  logic               img_readonly,
    input  logic [63:0]        img_size,
    track_cache_if.master      sd,
    input  logic [SEC_W+8:0]   fd_track_addr,
    input  logic               fd_write_disk,
    input  logic [7:0]         fd_data_do,
    output logic [7:0]         fd_data_in,
    output logic               cpu_wait_fdd,
    output logic               busy,
    output logic [SECTORS-1:0] dirty
);
    typedef enum logic [1:0] {IDLE, SCAN, WB_REQ, RD_REQ} state_t;
    localparam logic [SEC_W:0] NSEC = (SEC_W+1)'(SECTORS);
    localparam logic [SEC_W:0] LAST = (SEC_W+1)'(SECTORS - 1);
    state_t state, state_n;
    logic [SEC_W:0] sec_idx, sec_n;
    logic [TRACK_W-1:0] cur_track, cur_n, track_x, tx_n;
    logic load_after, la_n, rd_n, wr_n, wait_n, mnt_clr, wb_clr, scan_done, load;
    logic ack_d, mounted, readonly;
    logic [63:0] disk_size;
    logic [31:0] idle_cnt;
    logic [SECTORS-1:0] set_mask, clr_mask, sel_mask;
    logic [7:0] mem [0:(1<<(SEC_W+9))-1];
    logic [SEC_W+8:0] addr_a;
    logic [SEC_W-1:0] sec_w;
    logic we_a, we_b, we_dirty, ack_rise, ack_fall, flush_req, dirty_hit;
    assign addr_a    = {sec_idx[SEC_W-1:0], sd.sd_buff_addr};
    assign sec_w     = fd_track_addr[SEC_W+8:9];
    assign we_a      = sd.sd_buff_wr & sd.sd_ack;
    assign we_b      = fd_write_disk & active;
    assign we_dirty  = we_b & ~readonly;
    assign ack_rise  = sd.sd_ack & ~ack_d;
    assign ack_fall  = ~sd.sd_ack & ack_d;
    assign flush_req = (IDLE_FLUSH != 0) && idle_cnt == 32'(IDLE_FLUSH);
    // Writes beyond the last real sector land in BRAM but are never written back.
    assign set_mask  = (we_dirty && (SEC_W+1)'(sec_w) < NSEC) ? SECTORS'(1) << sec_w : '0;
    assign sel_mask  = SECTORS'(1) << sec_idx;
    assign clr_mask  = wb_clr ? sel_mask : '0;
    assign dirty_hit = |(dirty & sel_mask);
    assign busy      = state != IDLE;
    assign sd.lba_fdd = 32'(track_x) * 32'(SECTORS) + 32'(sec_idx);
    always_comb begin
        state_n = state;
        sec_n = sec_idx;
        tx_n = track_x;
        cur_n = cur_track;
        la_n = load_after;
        rd_n = sd.sd_rd;
        wr_n = sd.sd_wr;
        wait_n = cpu_wait_fdd;
        mnt_clr = 1'b0;
        wb_clr = 1'b0;
        scan_done = 1'b0;
        load = 1'b0;
        case (state)
            IDLE: if (disk_size != '0) begin
                if (track != cur_track || mounted) begin
                    mnt_clr = 1'b1;
                    wait_n = 1'b1;
                    sec_n = '0;
                    tx_n = cur_track;
                    la_n = 1'b1;
                    if (dirty != '0 && !readonly) state_n = SCAN;
                    else load = 1'b1;
                end else if (flush_req) begin
                    state_n = SCAN;
                    la_n = 1'b0;
                    sec_n = '0;
                    tx_n = cur_track;
                end
            end
            SCAN: if (sec_idx == NSEC) begin
                scan_done = 1'b1;
                if (load_after) load = 1'b1;
                else state_n = IDLE;
            end else if (dirty_hit) begin
                state_n = WB_REQ;
                wr_n = 1'b1;
                wb_clr = 1'b1;
            end else sec_n = sec_idx + 1'b1;
            WB_REQ: begin
                if (ack_rise) wr_n = 1'b0;
                if (ack_fall) begin
                    sec_n = sec_idx + 1'b1;
                    state_n = SCAN;
                end
            end
            RD_REQ: begin
                if (ack_rise) rd_n = 1'b0;
                if (ack_fall) begin
                    if (sec_idx == LAST) begin
                        state_n = IDLE;
                        wait_n = 1'b0;
                    end else begin
                        sec_n = sec_idx + 1'b1;
                        rd_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            state_n = RD_REQ;
            cur_n = track;
            tx_n = track;
            sec_n = '0;
            rd_n = 1'b1;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sec_idx <= '0;
            cur_track <= '1;
            track_x <= '0;
            load_after <= 1'b0;
            sd.sd_rd <= 1'b0;
            sd.sd_wr <= 1'b0;
            cpu_wait_fdd <= 1'b0;
            ack_d <= 1'b0;
            mounted <= 1'b0;
            readonly <= 1'b0;
            disk_size <= '0;
            dirty <= '0;
            idle_cnt <= '0;
        end else begin
            state <= state_n;
            sec_idx <= sec_n;
            cur_track <= cur_n;
            track_x <= tx_n;
            load_after <= la_n;
            sd.sd_rd <= rd_n;
            sd.sd_wr <= wr_n;
            cpu_wait_fdd <= wait_n;
            ack_d <= sd.sd_ack;
            mounted <= img_mounted | (mounted & ~mnt_clr);
            if (img_mounted) begin
                disk_size <= img_size;
                readonly <= img_readonly;
            end
            // A set on the clearing cycle wins so the sector gets rewritten next flush.
            dirty <= img_mounted ? '0 : (dirty & ~clr_mask) | set_mask;
            idle_cnt <= (we_dirty || scan_done || img_mounted) ? '0 :
                        (dirty != '0 && idle_cnt != 32'(IDLE_FLUSH)) ? idle_cnt + 1'b1 : idle_cnt;
        end
    end
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= sd.sd_buff_dout;
        if (we_b) mem[fd_track_addr] <= fd_data_do;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sd.sd_buff_din <= '0;
            fd_data_in <= '0;
        end else begin
            sd.sd_buff_din <= mem[addr_a];
            fd_data_in <= mem[fd_track_addr];
        end
    end
endmodule

// File: tb/tb_track_cache.sv
// tb_track_cache: directed/random bench for track_cache against an SD disk model and sector-level expectations.
module tb_track_cache;
    typedef int iq_t[$];
    localparam int SPT = 13;
    logic clk = 0, reset = 1, active = 0, img_mounted = 0, img_readonly = 0;
    logic [5:0] track = 0;
    logic [63:0] img_size = 0;
    logic [12:0] fd_track_addr = 0;
    logic fd_write_disk = 0;
    logic [7:0] fd_data_do = 0;
    logic [7:0] fd_data_in;
    logic cpu_wait_fdd, busy;
    logic [12:0] dirty;
    int checks = 0, errors = 0, cyc = 0, both_cnt = 0, late_cnt = 0;
    logic [7:0] sd_img [0:64*SPT*512-1];
    int rd_log[$], wr_log[$];
    bit r_wr, ack_prev = 0;
    int r_base;
    track_cache_if sd_if();
    track_cache #(.DRIVE_NUM(0), .SECTORS(SPT), .TRACK_W(6), .IDLE_FLUSH(100)) dut (
        .clk(clk), .reset(reset), .active(active), .track(track),
        .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
        .sd(sd_if), .fd_track_addr(fd_track_addr), .fd_write_disk(fd_write_disk),
        .fd_data_do(fd_data_do), .fd_data_in(fd_data_in), .cpu_wait_fdd(cpu_wait_fdd),
        .busy(busy), .dirty(dirty)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always begin
        @(negedge clk);
        #1;
        if (sd_if.sd_rd && sd_if.sd_wr) both_cnt++;
        if (ack_prev && sd_if.sd_ack && (sd_if.sd_rd || sd_if.sd_wr)) late_cnt++;
        ack_prev = sd_if.sd_ack;
    end
    // SD card model: serves one 512-byte sector per request out of sd_img.
    initial begin
        sd_if.sd_ack = 0;
        sd_if.sd_buff_wr = 0;
        sd_if.sd_buff_addr = 0;
        sd_if.sd_buff_dout = 0;
        forever begin
            @(negedge clk);
            if (!reset && (sd_if.sd_rd || sd_if.sd_wr)) begin
                r_wr = sd_if.sd_wr;
                r_base = int'(sd_if.lba_fdd) * 512;
                if (r_wr) wr_log.push_back(int'(sd_if.lba_fdd));
                else rd_log.push_back(int'(sd_if.lba_fdd));
                sd_if.sd_ack = 1;
                for (int i = 0; i <= 512; i++) begin
                    @(negedge clk);
                    if (reset) break;
                    if (r_wr) begin
                        if (i > 0) sd_img[r_base+i-1] = sd_if.sd_buff_din;
                        if (i < 512) sd_if.sd_buff_addr = 9'(i);
                    end else begin
                        sd_if.sd_buff_wr = (i < 512);
                        if (i < 512) begin
                            sd_if.sd_buff_addr = 9'(i);
                            sd_if.sd_buff_dout = sd_img[r_base+i];
                        end
                    end
                end
                sd_if.sd_buff_wr = 0;
                sd_if.sd_ack = 0;
            end
        end
    end
    initial begin
        #1200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic iq_t seq(input int first, input int n);
        iq_t q;
        for (int i = 0; i < n; i++) q.push_back(first + i);
        return q;
    endfunction
    task automatic check_q(input string tag, input iq_t got, input iq_t exp);
        check({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            check(tag, (i < got.size()) ? 64'(got[i]) : '1, 64'(exp[i]));
    endtask
    task automatic wait_idle(input string tag, input int budget, output int nowait);
        int n = 0;
        nowait = 0;
        repeat (4) @(negedge clk);
        while ((busy || sd_if.sd_rd || sd_if.sd_wr || sd_if.sd_ack) && n < budget) begin
            if (busy && !cpu_wait_fdd) nowait++;
            @(negedge clk);
            n++;
        end
        check({tag, "_in_time"}, 64'(n < budget), 1);
    endtask
    task automatic fd_wr(input logic [12:0] a, input logic [7:0] d);
        fd_track_addr = a;
        fd_data_do = d;
        fd_write_disk = 1;
        @(negedge clk);
        fd_write_disk = 0;
    endtask
    task automatic fd_rd(input logic [12:0] a, output logic [7:0] d);
        fd_track_addr = a;
        @(negedge clk);
        d = fd_data_in;
    endtask
    task automatic mount(input logic ro);
        img_readonly = ro;
        img_size = 64'd143360;
        img_mounted = 1;
        @(negedge clk);
        img_mounted = 0;
        img_readonly = 0;
    endtask
    logic [7:0] d, d0, d1, got;
    logic [12:0] a;
    logic [12:0] ra [3];
    logic [7:0] rv [3];
    int nw, cw, t0, first_wr, n;
    initial begin
        for (int i = 0; i < 64*SPT*512; i++) sd_img[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        check("rst_sd_rd", sd_if.sd_rd, 0);
        check("rst_sd_wr", sd_if.sd_wr, 0);
        check("rst_lba", sd_if.lba_fdd, 0);
        check("rst_wait", cpu_wait_fdd, 0);
        check("rst_busy", busy, 0);
        check("rst_dirty", dirty, 0);
        check("rst_fd_in", fd_data_in, 0);
        check("rst_buff_din", sd_if.sd_buff_din, 0);
        reset = 0;
        active = 1;
        @(negedge clk);
        // mount and initial load of track 0
        track = 0;
        mount(0);
        @(negedge clk);
        check("t1_wait_up", cpu_wait_fdd, 1);
        check("t1_rd_up", sd_if.sd_rd, 1);
        wait_idle("t1", 20000, nw);
        check("t1_wait_cover", nw, 0);
        check_q("t1_rd", rd_log, seq(0, SPT));
        check("t1_wait_down", cpu_wait_fdd, 0);
        for (int i = 0; i < 4; i++) begin
            a = 13'($urandom_range(0, SPT*512-1));
            fd_rd(a, got);
            check("t1_data", got, sd_img[a]);
        end
        // two dirty sectors written back on a track change
        rd_log.delete();
        track = 3;
        wait_idle("t2_load", 20000, nw);
        check_q("t2_rd3", rd_log, seq(39, SPT));
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        fd_wr(13'h0000, d0);
        fd_wr(13'h1805, d1);
        check("t2_dirty", dirty, 13'h1001);
        rd_log.delete();
        wr_log.delete();
        track = 4;
        wait_idle("t2_swap", 25000, nw);
        check("t2_wait_cover", nw, 0);
        check_q("t2_wr", wr_log, '{39, 51});
        check_q("t2_rd4", rd_log, seq(52, SPT));
        check("t2_img0", sd_img[39*512], d0);
        check("t2_img1", sd_img[51*512+5], d1);
        check("t2_dirty_clr", dirty, 0);
        // idle timeout flush without stalling the CPU
        rd_log.delete();
        wr_log.delete();
        track = 2;
        wait_idle("t3_load", 20000, nw);
        check_q("t3_rd", rd_log, seq(26, SPT));
        wr_log.delete();
        a = 13'(5*512 + $urandom_range(0, 511));
        d = 8'($urandom);
        fd_wr(a, d);
        check("t3_dirty", dirty, 13'h0020);
        t0 = cyc;
        first_wr = -1;
        cw = 0;
        n = 0;
        while (!(wr_log.size() >= 1 && !busy && !sd_if.sd_ack) && n < 1500) begin
            @(negedge clk);
            if (cpu_wait_fdd) cw++;
            if (sd_if.sd_wr && first_wr < 0) first_wr = cyc;
            n++;
        end
        check("t3_in_time", 64'(n < 1500), 1);
        check("t3_delay", 64'(first_wr - t0 >= 100 && first_wr - t0 <= 120), 1);
        check("t3_no_wait", cw, 0);
        check_q("t3_wr", wr_log, '{31});
        check("t3_dirty_clr", dirty, 0);
        check("t3_img", sd_img[26*512 + int'(a)], d);
        // read-only image: writes reach the buffer but never the card
        rd_log.delete();
        wr_log.delete();
        mount(1);
        wait_idle("t4_load", 20000, nw);
        check_q("t4_rd2", rd_log, seq(26, SPT));
        for (int i = 0; i < 3; i++) begin
            ra[i] = 13'(i*6*512 + $urandom_range(0, 511));
            rv[i] = 8'($urandom);
            fd_wr(ra[i], rv[i]);
        end
        check("t4_dirty", dirty, 0);
        for (int i = 0; i < 3; i++) begin
            fd_rd(ra[i], got);
            check("t4_readback", got, rv[i]);
        end
        rd_log.delete();
        track = 5;
        wait_idle("t4_swap", 20000, nw);
        check("t4_no_wr", wr_log.size(), 0);
        check_q("t4_rd5", rd_log, seq(65, SPT));
        // write colliding with the write-back clear keeps the sector dirty
        rd_log.delete();
        mount(0);
        wait_idle("t5_load", 20000, nw);
        check_q("t5_rd", rd_log, seq(65, SPT));
        wr_log.delete();
        a = 13'(4*512 + $urandom_range(0, 511));
        d = 8'($urandom);
        fd_wr(a, d);
        repeat (101) @(negedge clk);
        n = 0;
        while (n < 40) begin
            fd_track_addr = a;
            fd_data_do = d;
            fd_write_disk = 1;
            @(negedge clk);
            n++;
            if (sd_if.sd_wr) break;
        end
        fd_write_disk = 0;
        check("t5_wr_seen", sd_if.sd_wr, 1);
        n = 0;
        while (!(wr_log.size() >= 1 && !busy && !sd_if.sd_ack) && n < 1500) begin
            @(negedge clk);
            n++;
        end
        check("t5_first_in_time", 64'(n < 1500), 1);
        check("t5_dirty_kept", dirty, 13'h0010);
        n = 0;
        while (!(wr_log.size() >= 2 && !busy && !sd_if.sd_ack) && n < 1500) begin
            @(negedge clk);
            n++;
        end
        check("t5_second_in_time", 64'(n < 1500), 1);
        check_q("t5_wr", wr_log, '{69, 69});
        check("t5_dirty_clr", dirty, 0);
        check("t5_img", sd_img[65*512 + int'(a)], d);
        // asynchronous reset during the sixth sector read
        rd_log.delete();
        wr_log.delete();
        track = 6;
        n = 0;
        while (!(rd_log.size() >= 6 && sd_if.sd_ack) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("t6_sixth_in_time", 64'(n < 5000), 1);
        repeat (50) @(negedge clk);
        check("t6_wait_before", cpu_wait_fdd, 1);
        #2 reset = 1;
        #1;
        check("t6_rst_rd", sd_if.sd_rd, 0);
        check("t6_rst_wait", cpu_wait_fdd, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_dirty", dirty, 0);
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        rd_log.delete();
        mount(0);
        wait_idle("t6_reload", 20000, nw);
        check_q("t6_rd", rd_log, seq(78, SPT));
        check("t6_no_wr", wr_log.size(), 0);
        for (int i = 0; i < 3; i++) begin
            a = 13'($urandom_range(0, SPT*512-1));
            fd_rd(a, got);
            check("t6_data", got, sd_img[78*512 + int'(a)]);
        end
        check("both_req", both_cnt, 0);
        check("req_after_ack", late_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
